// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the execute-stage issuer and alu_multicycle.
// ALU_OVERFLOW_EN adds the registered overflow flag to the response side.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       aluOp;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             out_valid;
`ifdef ALU_OVERFLOW_EN
  logic             overflow;

  modport master (
    output aluOp, data1, data2, in_valid,
    input  in_ready, result, zero, out_valid, overflow
  );
  modport slave (
    input  aluOp, data1, data2, in_valid,
    output in_ready, result, zero, out_valid, overflow
  );
`else
  modport master (
    output aluOp, data1, data2, in_valid,
    input  in_ready, result, zero, out_valid
  );
  modport slave (
    input  aluOp, data1, data2, in_valid,
    output in_ready, result, zero, out_valid
  );
`endif
endinterface

// File: rtl/alu_multicycle.sv
// Registered ALU: single-cycle logic/arith ops plus iterative MUL/DIVU/REMU over WIDTH cycles.
// Optional macro ALU_OVERFLOW_EN adds a signed/multiply overflow flag (2*WIDTH-bit multiplier).
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  alu_multicycle_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  // a: multiplier / dividend->quotient, b: multiplicand / divisor, p: accumulator / remainder
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] add_res, sub_res;
  logic [WIDTH-1:0] mul_a, mul_b, mul_p, mul_lo;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_a, div_p;
  logic [WIDTH-1:0] iter_res;

`ifdef ALU_OVERFLOW_EN
  logic             ovf_q, ovf_d;
  logic             alu_ovf;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi;
`endif

  function automatic logic is_iter(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  always_comb begin
    add_res = bus.data1 + bus.data2;
    sub_res = bus.data1 - bus.data2;
    case (bus.aluOp)
      OP_AND:  alu_res = bus.data1 & bus.data2;
      OP_OR:   alu_res = bus.data1 | bus.data2;
      OP_ADD:  alu_res = add_res;
      OP_SUB:  alu_res = sub_res;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.data1) < $signed(bus.data2))};
      OP_NOR:  alu_res = ~(bus.data1 | bus.data2);
      default: alu_res = '0;
    endcase
`ifdef ALU_OVERFLOW_EN
    case (bus.aluOp)
      OP_ADD:  alu_ovf = (bus.data1[WIDTH-1] == bus.data2[WIDTH-1]) &&
                         (add_res[WIDTH-1] != bus.data1[WIDTH-1]);
      OP_SUB:  alu_ovf = (bus.data1[WIDTH-1] != bus.data2[WIDTH-1]) &&
                         (sub_res[WIDTH-1] != bus.data1[WIDTH-1]);
      default: alu_ovf = 1'b0;
    endcase
`endif
  end

  // One iteration of each iterative algorithm, evaluated from the current registers.
  always_comb begin
`ifdef ALU_OVERFLOW_EN
    // {p,a} is the 2*WIDTH product register; the multiplier drains out of a as product bits enter.
    mul_sum = {1'b0, p_q} + ({1'b0, b_q} & {(WIDTH+1){a_q[0]}});
    mul_p   = mul_sum[WIDTH:1];
    mul_a   = {mul_sum[0], a_q[WIDTH-1:1]};
    mul_b   = b_q;
    mul_lo  = mul_a;
    mul_hi  = mul_p;
`else
    mul_p   = p_q + (b_q & {WIDTH{a_q[0]}});
    mul_a   = a_q >> 1;
    mul_b   = b_q << 1;
    mul_lo  = mul_p;
`endif
    // Restoring division: a zero divisor always "fits", yielding all-ones and remainder = dividend.
    div_shift = {p_q, a_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_p     = div_ge ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
    div_a     = {a_q[WIDTH-2:0], div_ge};

    case (op_q)
      OP_MUL:  iter_res = mul_lo;
      OP_DIVU: iter_res = div_a;
      default: iter_res = div_p;
    endcase
  end

  always_comb begin
    // NOTE: every *_d is given its hold value first so no branch below can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    in_ready_d  = in_ready_q;
    a_d         = a_q;
    b_d         = b_q;
    p_d         = p_q;
`ifdef ALU_OVERFLOW_EN
    ovf_d       = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d       = bus.aluOp;
          in_ready_d = 1'b0;
          if (is_iter(bus.aluOp)) begin
            state_d = BUSY;
            cnt_d   = CNT_W'(WIDTH);
            a_d     = bus.data1;
            b_d     = bus.data2;
            p_d     = '0;
          end else begin
            state_d     = DONE;
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            out_valid_d = 1'b1;
`ifdef ALU_OVERFLOW_EN
            ovf_d       = alu_ovf;
`endif
          end
        end
      end

      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (op_q == OP_MUL) begin
          a_d = mul_a;
          b_d = mul_b;
          p_d = mul_p;
        end else begin
          a_d = div_a;
          p_d = div_p;
        end
        if (cnt_q == CNT_W'(1)) begin
          state_d     = DONE;
          result_d    = iter_res;
          zero_d      = (iter_res == '0);
          out_valid_d = 1'b1;
`ifdef ALU_OVERFLOW_EN
          ovf_d       = (op_q == OP_MUL) && (mul_hi != '0);
`endif
        end
      end

      DONE: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end

      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef ALU_OVERFLOW_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef ALU_OVERFLOW_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  // NOTE: operand/working registers are left unreset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    op_q <= op_d;
    a_q  <= a_d;
    b_q  <= b_d;
    p_q  <= p_d;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.out_valid = out_valid_q;
`ifdef ALU_OVERFLOW_EN
  assign bus.overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: driver pushes model results, negedge monitor pops on out_valid.
// Overflow checks are compiled in when ALU_OVERFLOW_EN is defined.
module tb_alu_multicycle;
  localparam int W = 32;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;

  alu_multicycle_if #(.WIDTH(W)) bus ();

  alu_multicycle #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] res;
    logic         zero;
    logic         ovf;
    int           acc;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   prev_acc;
  int   prev_lat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit iter_op(input logic [3:0] op);
    return (op == 4'b1000) || (op == 4'b1001) || (op == 4'b1010);
  endfunction

  // Reference model: plain arithmetic on the architectural definition of each opcode.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic ov);
    logic [63:0] prod;
    ov = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin r = a + b; ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      4'b0110: begin r = a - b; ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      4'b0111: r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'b1100: r = ~(a | b);
      4'b1000: begin prod = 64'(a) * 64'(b); r = prod[W-1:0]; ov = (prod[63:W] != 0); end
      4'b1001: r = (b == 0) ? '1 : a / b;
      4'b1010: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit jitter);
    exp_t e;
    int   n;
    n = 0;
    bus.in_valid = 1'b1;
    while (!bus.in_ready) begin
      if (n > 200) begin
        check("accept_timeout", 64'(n), 64'd0);
        bus.in_valid = 1'b0;
        return;
      end
      if (jitter) begin
        bus.aluOp = 4'($urandom);
        bus.data1 = $urandom;
        bus.data2 = $urandom;
      end else begin
        bus.aluOp = op;
        bus.data1 = a;
        bus.data2 = b;
      end
      n++;
      @(negedge clk);
    end
    bus.aluOp = op;
    bus.data1 = a;
    bus.data2 = b;
    e.op  = op;
    model(op, a, b, e.res, e.ovf);
    e.zero = (e.res == 0);
    e.acc  = cyc + 1;
    e.lat  = iter_op(op) ? W + 1 : 1;
    if (n > 0 && prev_acc >= 0)
      check("issue_gap", 64'(e.acc - prev_acc), 64'(prev_lat + 1));
    prev_acc = e.acc;
    prev_lat = e.lat;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (jitter) begin
      bus.data1 = $urandom;
      bus.data2 = $urandom;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (sb.size() > 0)
        check("in_ready_busy", 64'(bus.in_ready), 64'd0);
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 64'(bus.out_valid), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check($sformatf("result op=%0h", e.op), 64'(bus.result), 64'(e.res));
          check($sformatf("zero op=%0h", e.op), 64'(bus.zero), 64'(e.zero));
          check($sformatf("latency op=%0h", e.op), 64'(cyc - e.acc + 1), 64'(e.lat));
`ifdef ALU_OVERFLOW_EN
          check($sformatf("overflow op=%0h", e.op), 64'(bus.overflow), 64'(e.ovf));
`endif
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_result"}, 64'(bus.result), 64'd0);
    check({tag, "_zero"}, 64'(bus.zero), 64'd1);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
`ifdef ALU_OVERFLOW_EN
    check({tag, "_overflow"}, 64'(bus.overflow), 64'd0);
`endif
  endtask

  logic [3:0] ops [10];

  initial begin
    cyc = 0; total = 0; bad = 0;
    prev_acc = -1; prev_lat = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.aluOp = 4'h0;
    bus.data1 = '0;
    bus.data2 = '0;
    ops = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'h8, 4'h9, 4'hA, 4'h3};

    repeat (3) @(negedge clk);
    // Reset wins over a simultaneous request.
    bus.in_valid = 1'b1;
    bus.aluOp = 4'h2;
    bus.data1 = 32'd5;
    bus.data2 = 32'd6;
    @(negedge clk);
    check_reset_state("reset");
    bus.in_valid = 1'b0;
    reset = 1'b0;

    issue(4'h0, 32'h0000_000F, 32'h0000_0007, 1'b0);
    issue(4'h6, 32'h0000_000F, 32'h0000_0007, 1'b0);
    issue(4'h6, 32'h0000_0007, 32'h0000_000F, 1'b0);
    issue(4'h7, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    issue(4'hC, 32'h0000_0000, 32'h0000_0000, 1'b0);
    issue(4'h3, 32'h1234_5678, 32'h0000_0001, 1'b0);
    issue(4'h2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    issue(4'h6, 32'h8000_0000, 32'h0000_0001, 1'b0);
    issue(4'h8, 32'h0001_0000, 32'h0001_0000, 1'b0);
    issue(4'h9, 32'd100, 32'd7, 1'b0);
    issue(4'hA, 32'd100, 32'd7, 1'b0);
    issue(4'h9, 32'd5, 32'd0, 1'b0);
    issue(4'hA, 32'd5, 32'd0, 1'b0);
    issue(4'h8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    // Held request with changing data while the block is busy.
    issue(4'h8, 32'h0000_1234, 32'h0000_5678, 1'b0);
    issue(4'h9, 32'hDEAD_BEEF, 32'h0000_0013, 1'b1);
    issue(4'h2, 32'h0000_0010, 32'h0000_0020, 1'b1);

    // Reset in the middle of a MUL: the operation is dropped without an out_valid pulse.
    repeat (3) @(negedge clk);
    issue(4'h8, 32'h0000_0003, 32'h0000_0005, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("midbusy_reset");
    prev_acc = -1;
    repeat (40) @(negedge clk);
    issue(4'h2, 32'd1, 32'd2, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      op = ops[$urandom_range(0, 9)];
      case ($urandom_range(0, 3))
        0:       a = '0;
        1:       a = '1;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = '1;
        2:       b = W'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      issue(op, a, b, $urandom_range(0, 1) == 1);
    end

    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
